// File: rtl/debounce_pkg.sv
// Shared types for the debounce / edge-detect block: the qualification FSM states.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } deb_state_e;

endpackage : debounce_pkg

// File: rtl/debounce_edge_det_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous input into the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw input through the flop chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_edge_det.sv
// Synchronizes and debounces d_i, producing a clean level, rise/fall pulses and a rise count.
// Macro DEBOUNCE_FILTER_EN enables the stability-qualification FSM; without it the level follows sync_s.
module debounce_edge_det
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] rise_cnt_o
);

    generate
        if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
            $error("debounce_edge_det: SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2");
        end
    endgenerate

    logic             sync_s;
    logic             level_r;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] rise_cnt_r;
    logic             level_nxt_s;
    logic             rise_nxt_s;
    logic             fall_nxt_s;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk   (clk),
        .reset (reset),
        .d     (d_i),
        .q     (sync_s)
    );

`ifdef DEBOUNCE_FILTER_EN
    // cnt never exceeds DEBOUNCE_CYCLES-1, so clog2(DEBOUNCE_CYCLES) bits suffice.
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    deb_state_e      state_r;
    deb_state_e      state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;

    // FSM state and stability counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= LOW;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Qualification: a new level is accepted only after DEBOUNCE_CYCLES equal samples.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        case (state_r)
            LOW: begin
                if (sync_s) begin
                    state_nxt_s = CHK_HI;
                    cnt_nxt_s   = CW'(1);
                end else begin
                    state_nxt_s = LOW;
                end
            end
            CHK_HI: begin
                if (!sync_s) begin
                    state_nxt_s = LOW;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = HIGH;
                    cnt_nxt_s   = '0;
                    level_nxt_s = 1'b1;
                    rise_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                end
            end
            HIGH: begin
                if (!sync_s) begin
                    state_nxt_s = CHK_LO;
                    cnt_nxt_s   = CW'(1);
                end else begin
                    state_nxt_s = HIGH;
                end
            end
            CHK_LO: begin
                if (sync_s) begin
                    state_nxt_s = HIGH;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = LOW;
                    cnt_nxt_s   = '0;
                    level_nxt_s = 1'b0;
                    fall_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s = LOW;
                cnt_nxt_s   = '0;
                level_nxt_s = 1'b0;
            end
        endcase
    end
`else
    // Unfiltered: level tracks the synchronized input, edges come from its change.
    always_comb begin
        level_nxt_s = sync_s;
        rise_nxt_s  = sync_s & ~level_r;
        fall_nxt_s  = ~sync_s & level_r;
    end
`endif

    // Registered outputs and the wrapping rise counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r    <= 1'b0;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
            rise_cnt_r <= '0;
        end else begin
            level_r <= level_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
            if (rise_nxt_s) begin
                rise_cnt_r <= rise_cnt_r + CNT_W'(1);
            end else begin
                rise_cnt_r <= rise_cnt_r;
            end
        end
    end

    assign level_o    = level_r;
    assign rise_o     = rise_r;
    assign fall_o     = fall_r;
    assign rise_cnt_o = rise_cnt_r;

endmodule : debounce_edge_det

// File: tb/tb_debounce_edge_det.sv
// Self-checking bench for debounce_edge_det (default parameters); follows DEBOUNCE_FILTER_EN if defined.
module tb_debounce_edge_det;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int CNT_W = 8;
`ifdef DEBOUNCE_FILTER_EN
    localparam int LAT = SYNC + DEB;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic             clk;
    logic             reset;
    logic             d_i;
    logic             level_o;
    logic             rise_o;
    logic             fall_o;
    logic [CNT_W-1:0] rise_cnt_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state: raw sample history, synchronized sample history, outputs.
    bit               d_hist[$];
    bit               s_hist[$];
    logic             m_level;
    logic             m_rise;
    logic             m_fall;
    logic [CNT_W-1:0] m_cnt;

    debounce_edge_det #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_i        (d_i),
        .level_o    (level_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .rise_cnt_o (rise_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level flips once the last DEB synchronized samples all oppose it.
    task automatic model_step(input logic d, input logic r);
        bit s;
        bit all_opp;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (r) begin
            d_hist.delete();
            s_hist.delete();
            m_level = 1'b0;
            m_cnt   = '0;
        end else begin
            d_hist.push_back(d);
            if (d_hist.size() > SYNC + 1) void'(d_hist.pop_front());
            s = (d_hist.size() == SYNC + 1) ? d_hist[0] : 1'b0;
`ifdef DEBOUNCE_FILTER_EN
            s_hist.push_back(s);
            if (s_hist.size() > DEB) void'(s_hist.pop_front());
            all_opp = (s_hist.size() == DEB);
            foreach (s_hist[i]) if (s_hist[i] == m_level) all_opp = 1'b0;
`else
            all_opp = (s != m_level);
`endif
            if (all_opp) begin
                m_level = ~m_level;
                m_rise  = m_level;
                m_fall  = ~m_level;
                s_hist.delete();
            end
            if (m_rise) m_cnt = m_cnt + 8'd1;
        end
    endtask

    task automatic tick(input logic d, input logic r);
        d_i   = d;
        reset = r;
        @(posedge clk);
        model_step(d, r);
        #1;
    endtask

    task automatic test_reset();
        int lvl_edge = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            total_cnt++;
            if ({level_o, rise_o, fall_o, rise_cnt_o} !== 11'd0)
                $display("FAIL reset_outputs: got %b/%b/%b/%0d expected all 0", level_o, rise_o, fall_o, rise_cnt_o);
            else pass_cnt++;
        end
        for (int e = 1; e <= 20; e++) begin
            tick(1'b1, 1'b0);
            if (level_o === 1'b1 && lvl_edge == 0) lvl_edge = e;
        end
        total_cnt++;
        if (lvl_edge !== LAT) $display("FAIL reset_release_latency: got edge %0d expected %0d", lvl_edge, LAT);
        else pass_cnt++;
    endtask

    task automatic test_rise();
        int rise_edge = 0;
        int rises = 0;
        logic [CNT_W-1:0] cnt0;
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
        cnt0 = m_cnt;
        for (int e = 1; e <= 10; e++) begin
            tick(1'b1, 1'b0);
            if (rise_o === 1'b1) begin
                rises++;
                if (rise_edge == 0) rise_edge = e;
            end
            total_cnt++;
            if ({level_o, rise_o, fall_o, rise_cnt_o} !== {m_level, m_rise, m_fall, m_cnt})
                $display("FAIL rise_model: edge %0d got %b%b%b/%0d expected %b%b%b/%0d", e,
                         level_o, rise_o, fall_o, rise_cnt_o, m_level, m_rise, m_fall, m_cnt);
            else pass_cnt++;
        end
        total_cnt++;
        if (rise_edge !== LAT || rises !== 1) $display("FAIL rise_pulse: got edge %0d count %0d expected edge %0d count 1", rise_edge, rises, LAT);
        else pass_cnt++;
        total_cnt++;
        if (level_o !== 1'b1 || rise_cnt_o !== cnt0 + 8'd1) $display("FAIL rise_level_cnt: got %b/%0d expected 1/%0d", level_o, rise_cnt_o, cnt0 + 8'd1);
        else pass_cnt++;
    endtask

    task automatic test_fall();
        int fall_edge = 0;
        int falls = 0;
        logic [CNT_W-1:0] cnt0;
        cnt0 = rise_cnt_o;
        for (int e = 1; e <= 10; e++) begin
            tick(1'b0, 1'b0);
            if (fall_o === 1'b1) begin
                falls++;
                if (fall_edge == 0) fall_edge = e;
            end
        end
        total_cnt++;
        if (fall_edge !== LAT || falls !== 1) $display("FAIL fall_pulse: got edge %0d count %0d expected edge %0d count 1", fall_edge, falls, LAT);
        else pass_cnt++;
        total_cnt++;
        if (level_o !== 1'b0 || rise_cnt_o !== cnt0) $display("FAIL fall_level_cnt: got %b/%0d expected 0/%0d", level_o, rise_cnt_o, cnt0);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        logic [CNT_W-1:0] cnt0;
        int rise_edge = 0;
        int fall_edge = 0;
        int any_level = 0;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        cnt0 = rise_cnt_o;
`ifdef DEBOUNCE_FILTER_EN
        for (int e = 1; e <= 13; e++) begin
            tick((e <= 3) ? 1'b1 : 1'b0, 1'b0);
            if (level_o !== 1'b0 || rise_o !== 1'b0) any_level++;
        end
        total_cnt++;
        if (any_level !== 0 || rise_cnt_o !== cnt0) $display("FAIL glitch_filtered: got %0d bad cycles cnt %0d expected 0 cnt %0d", any_level, rise_cnt_o, cnt0);
        else pass_cnt++;
`else
        for (int e = 1; e <= 8; e++) begin
            tick((e == 1) ? 1'b1 : 1'b0, 1'b0);
            if (rise_o === 1'b1 && rise_edge == 0) rise_edge = e;
            if (fall_o === 1'b1 && fall_edge == 0) fall_edge = e;
        end
        total_cnt++;
        if (rise_edge !== 3 || fall_edge !== 4) $display("FAIL glitch_pass: got rise %0d fall %0d expected rise 3 fall 4", rise_edge, fall_edge);
        else pass_cnt++;
        total_cnt++;
        if (rise_cnt_o !== cnt0 + 8'd1) $display("FAIL glitch_cnt: got %0d expected %0d", rise_cnt_o, cnt0 + 8'd1);
        else pass_cnt++;
`endif
    endtask

    task automatic test_random();
        logic d = 1'b0;
        int hold = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                d = $urandom_range(1, 0);
                hold = ($urandom_range(3, 0) == 0) ? $urandom_range(12, 5) : $urandom_range(4, 1);
            end
            hold--;
            tick(d, ($urandom_range(199, 0) == 0) ? 1'b1 : 1'b0);
            total_cnt++;
            if ({level_o, rise_o, fall_o, rise_cnt_o} !== {m_level, m_rise, m_fall, m_cnt})
                $display("FAIL random_model: cycle %0d got %b%b%b/%0d expected %b%b%b/%0d", i,
                         level_o, rise_o, fall_o, rise_cnt_o, m_level, m_rise, m_fall, m_cnt);
            else pass_cnt++;
            total_cnt++;
            if ((rise_o & fall_o) !== 1'b0) $display("FAIL random_exclusive: cycle %0d got rise&fall=%b expected 0", i, rise_o & fall_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 256; k++) begin
            for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
            if (k == 255) begin
                total_cnt++;
                if (rise_cnt_o !== 8'd255) $display("FAIL wrap_255: got %0d expected 255", rise_cnt_o);
                else pass_cnt++;
            end
            if (k == 256) begin
                total_cnt++;
                if (rise_cnt_o !== 8'd0 || m_cnt !== 8'd0) $display("FAIL wrap_0: got %0d expected 0", rise_cnt_o);
                else pass_cnt++;
            end
            for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int rise_edge = 0;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        total_cnt++;
        if ({level_o, rise_o, rise_cnt_o} !== 10'd0) $display("FAIL reset_mid_clear: got %b%b/%0d expected 00/0", level_o, rise_o, rise_cnt_o);
        else pass_cnt++;
        for (int e = 1; e <= 10; e++) begin
            tick(1'b1, 1'b0);
            if (rise_o === 1'b1 && rise_edge == 0) rise_edge = e;
        end
        total_cnt++;
        if (rise_edge !== LAT) $display("FAIL reset_mid_requalify: got edge %0d expected %0d", rise_edge, LAT);
        else pass_cnt++;
    endtask

    initial begin
        reset   = 1'b1;
        d_i     = 1'b0;
        m_level = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_cnt   = '0;
        test_reset();
        test_rise();
        test_fall();
        test_glitch();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_debounce_edge_det

// File: doc/debounce_edge_det.md
DEBOUNCE_EDGE_DET -- requirements
Module: debounce_edge_det

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth (legal >= 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the consecutive stable samples required to qualify a level (legal >= 2).
REQ-003 SHALL have parameter CNT_W, default 8, meaning the rise counter width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning the synchronous, active-high reset.
REQ-006 SHALL have port d_i, input, 1, meaning the raw input, asynchronous to clk and possibly bouncing.
REQ-007 SHALL have port level_o, output, 1, meaning the debounced, registered level.
REQ-008 SHALL have port rise_o, output, 1, meaning a one-cycle pulse on a qualified 0->1 of level_o.
REQ-009 SHALL have port fall_o, output, 1, meaning a one-cycle pulse on a qualified 1->0 of level_o.
REQ-010 SHALL have port rise_cnt_o, output, CNT_W, meaning the count of qualified rises.

Function
REQ-011 SHALL pass d_i through a SYNC_STAGES flop chain; its last stage is sync_s.
REQ-012 SHALL implement FSM states LOW, CHK_HI, HIGH, CHK_LO with a stability counter cnt.
REQ-013 SHALL, in LOW, move to CHK_HI with cnt=1 when sync_s=1, and otherwise hold.
REQ-014 SHALL, in CHK_HI, return to LOW with cnt=0 when sync_s=0; move to HIGH when sync_s=1 and cnt=DEBOUNCE_CYCLES-1; and otherwise increment cnt.
REQ-015 SHALL make HIGH and CHK_LO the mirror images of LOW and CHK_HI, with sync_s inverted.
REQ-016 SHALL set level_o=1 and rise_o=1 for exactly one cycle on the CHK_HI->HIGH transition, and level_o=0 and fall_o=1 for exactly one cycle on the CHK_LO->LOW transition.
REQ-017 SHALL have a latency of SYNC_STAGES+DEBOUNCE_CYCLES clk edges from the first edge sampling a stable new d_i to level_o changing (6 at defaults).
REQ-018 SHALL discard any pulse on sync_s shorter than DEBOUNCE_CYCLES samples, with no change to level_o, rise_o, fall_o or rise_cnt_o.
REQ-019 SHALL never assert rise_o and fall_o in the same cycle.
REQ-020 SHALL increment rise_cnt_o by 1 in the cycle rise_o is asserted, wrapping from 2^CNT_W-1 to 0 with no sticky flag.

Reset
REQ-021 SHALL, while reset=1 at a clk edge, clear all synchronizer flops, cnt, level_o, rise_o, fall_o and rise_cnt_o to 0, and set the FSM to LOW.
REQ-022 SHALL, on reset asserted mid-qualification (CHK_HI or CHK_LO), abandon the qualification; after release, a high d_i is re-qualified from scratch with full latency.
REQ-023 SHALL give reset priority over all other events in the same cycle.

Configuration
REQ-024 SHALL, with macro DEBOUNCE_FILTER_EN defined, build the FSM and counter as in REQ-012..REQ-018.
REQ-025 SHALL, without DEBOUNCE_FILTER_EN, register level_o directly from sync_s (latency SYNC_STAGES+1), derive rise_o and fall_o from the level_o change, keep rise_cnt_o unchanged in behaviour, and not instantiate the FSM or cnt.

Structure
REQ-026 SHALL define the FSM state enum (LOW, CHK_HI, HIGH, CHK_LO) in shared package debounce_pkg.
REQ-027 SHALL use one sub-module, sync_chain (parameter STAGES, synchronous active-high reset), for the synchronizer.
REQ-028 SHALL fail elaboration if SYNC_STAGES < 2 or DEBOUNCE_CYCLES < 2.

Verification (defaults, macro defined unless stated)
REQ-029 SHALL cover: d_i=1 during 3 reset cycles -> all outputs 0; after release, level_o=1 at the 6th edge.
REQ-030 SHALL cover: d_i 0->1 held 10 cycles -> rise_o high for exactly 1 cycle at edge 6, level_o=1, rise_cnt_o=1.
REQ-031 SHALL cover: d_i high for 3 cycles, then low -> level_o, rise_o and rise_cnt_o stay 0.
REQ-032 SHALL cover: from HIGH, d_i low held 10 cycles -> fall_o one cycle at edge 6, rise_cnt_o unchanged.
REQ-033 SHALL cover: 256 qualified rises -> rise_cnt_o reads 255 then 0; reset in CHK_HI -> no rise_o.
REQ-034 SHALL cover, with macro undefined: a 1-cycle d_i pulse -> rise_o at edge 3 and fall_o at edge 4.
